axi_mmio2lite: RTL
==================

Name: axi_mmio2lite

Overview:
- Reverse-direction companion to the ToD AXI-Lite-to-MMIO bridge.
- Accepts AXI4 MMIO requests (IDs, len, burst) as a responder and re-issues them as AXI-Lite master transactions toward a CSR block.
- Returns ID-tagged AXI4 responses.
- Sits between the AFU MMIO fabric and AXI-Lite-only CSR slaves. Single-beat MMIO is forwarded; bursts are drained and rejected locally.

Parameters:
- ADDR_W, 18, address width on both sides; no truncation.
- DATA_W, 64, data width on both sides; strobe width DATA_W/8.
- ID_W, 9, AXI4 ID width on the MMIO side.

Ports:
- clk  input  1  single clock for both interfaces
- rst  input  1  synchronous, active-high reset
- mmio_if  ofs_fim_axi_mmio_if.slave  ADDR_W/DATA_W/ID_W  AXI4 MMIO responder side (AW/W/B/AR/R)
- lite_if  ofs_fim_axi_lite_if.master  ADDR_W/DATA_W  AXI-Lite initiator side (AW/W/B/AR/R)

Behaviour:
- All handshake outputs are registered. While rst is high, every valid/ready output is 0 and the data/ID/resp outputs are 0. Both FSMs go to IDLE; any in-flight transaction is dropped with no response.
- mmio awready/arready rise on the first cycle after rst deasserts.
- Write and read paths are independent FSMs with at most 1 outstanding transaction each. Concurrent read and write are allowed.

Write FSM:
- W_IDLE: awready=1, wready=0.
  - On awvalid: capture awid, awaddr, awprot, awlen.
  - awlen==0 -> W_DATA; else -> W_DRAIN.
- W_DATA: wready=1. On wvalid, capture wdata and wstrb -> W_LITE. A W beat that arrives before AW stalls (wready=0 in IDLE).
- W_LITE: lite awvalid and lite wvalid are asserted together. Each drops independently on its own ready. When both have been accepted -> W_RESP. Same-cycle and either-order acceptance must both work.
- W_RESP: lite bready=1. On lite bvalid, capture bresp -> W_BOUT.
- W_DRAIN: wready=1. Discard beats until wvalid&wlast. Force resp=SLVERR (2'b10) -> W_BOUT. No lite traffic is issued.
- W_BOUT: mmio bvalid=1, bid=captured awid, bresp=captured. Hold until bready -> W_IDLE. awready reasserts on the next cycle.
- Minimum single-beat latency, zero-wait CSR: AW accept at cycle 0, W accept at cycle 1, lite AW/W at cycle 2, lite B at cycle 3, mmio bvalid at cycle 4.

Read FSM:
- R_IDLE: arready=1. On arvalid, capture arid, araddr, arprot, and arlen into an 8-bit beat counter. arlen==0 -> R_LITE; else -> R_ERR.
- R_LITE: lite arvalid=1 until arready -> R_WAIT.
- R_WAIT: lite rready=1. On rvalid, capture rdata and rresp -> R_OUT.
- R_OUT: mmio rvalid=1, rid=arid, rlast=1, rdata/rresp as captured. On rready -> R_IDLE.
- R_ERR: emits arlen+1 beats with rdata=0, rresp=SLVERR, rid=arid. rlast=1 only on the final beat.
  - The counter decrements per rvalid&rready.
  - At counter 0 with handshake -> R_IDLE.
  - arlen=255 must yield exactly 256 beats with no counter wrap.
- Minimum single-beat read latency: AR accept at cycle 0, lite AR at cycle 1, lite R at cycle 2, mmio rvalid at cycle 3.

General rules:
- awsize, awburst, awcache, awqos and the ar equivalents are ignored.
- lite bresp/rresp values (OKAY, SLVERR, DECERR) pass through unmodified.
- Valid outputs never drop without a handshake. Data/ID fields are stable while valid is high.

Test Plan:
- Single write: awid=0x1A5, awaddr=0x0040, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF; CSR returns OKAY -> one lite write to 0x0040 with the same data/strb; mmio bid=0x1A5, bresp=0; earliest bvalid at cycle 4.
- Write with W before AW by 3 cycles, plus lite awready delayed 2 cycles after wready -> wready stays 0 until AW is accepted; exactly one lite AW and one lite W; single B response.
- Burst write awlen=3 -> 4 W beats accepted; zero lite transactions; bresp=2'b10; bid echoed.
- Single read araddr=0x0100, arid=0x007; CSR returns rdata=0x1234, rresp=DECERR -> mmio rdata=0x1234, rresp=2'b11, rid=0x007, rlast=1.
- Burst read arlen=255 with rready toggling every cycle -> exactly 256 beats, all SLVERR with rdata=0; rlast only on beat 256; no lite AR issued.
- rst pulsed for 1 cycle while in W_RESP and R_WAIT -> all valids 0 the next cycle; no mmio B/R issued; awready/arready=1 on the following cycle; a new single write completes normally.

Source files
------------

// File: rtl/axi_mmio2lite_if.sv
// AXI4 MMIO (with IDs/len) and AXI-Lite bus bundles used by
// the MMIO-to-Lite bridge.
interface ofs_fim_axi_mmio_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 64,
  parameter int ID_W   = 9
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_W-1:0]       awid;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [ID_W-1:0]       bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ID_W-1:0]       arid;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [ID_W-1:0]       rid;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awprot,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arprot,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arprot,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

interface ofs_fim_axi_lite_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 64
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;

  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/axi_mmio2lite.sv
// AXI4 MMIO responder re-issuing single beats as AXI-Lite;
// bursts are drained and answered locally with SLVERR.
module axi_mmio2lite #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 64,
  parameter int ID_W   = 9
) (
  input  logic clk,
  input  logic rst,
  ofs_fim_axi_mmio_if.slave  mmio_if,
  ofs_fim_axi_lite_if.master lite_if
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_DATA,
    W_LITE,
    W_RESP,
    W_DRAIN,
    W_BOUT
  } w_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_LITE,
    R_WAIT,
    R_OUT,
    R_ERR
  } r_state_t;

  w_state_t r_wstate;
  w_state_t w_wnext;
  r_state_t r_rstate;
  r_state_t w_rnext;

  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic              r_law_valid;
  logic              r_lw_valid;
  logic              r_lb_ready;
  logic              r_aw_done;
  logic              r_w_done;
  logic [ID_W-1:0]   r_awid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [2:0]        r_awprot;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [1:0]        r_bresp;

  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic              r_lar_valid;
  logic              r_lr_ready;
  logic [7:0]        r_cnt;
  logic [ID_W-1:0]   r_arid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_law_hs;
  logic       w_lw_hs;
  logic       w_lb_hs;
  logic       w_b_hs;
  logic       w_aw_done;
  logic       w_w_done;
  logic       w_ar_hs;
  logic       w_lar_hs;
  logic       w_lr_hs;
  logic       w_r_hs;
  logic [7:0] w_cnt_next;

  assign w_aw_hs  = mmio_if.awvalid & r_awready;
  assign w_w_hs   = mmio_if.wvalid & r_wready;
  assign w_law_hs = r_law_valid & lite_if.awready;
  assign w_lw_hs  = r_lw_valid & lite_if.wready;
  assign w_lb_hs  = r_lb_ready & lite_if.bvalid;
  assign w_b_hs   = r_bvalid & mmio_if.bready;

  assign w_ar_hs  = mmio_if.arvalid & r_arready;
  assign w_lar_hs = r_lar_valid & lite_if.arready;
  assign w_lr_hs  = r_lr_ready & lite_if.rvalid;
  assign w_r_hs   = r_rvalid & mmio_if.rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  // Lite AW and W complete independently; each done flag
  // lives only while in W_LITE.
  always_comb begin
    w_wnext   = r_wstate;
    w_aw_done = 1'b0;
    w_w_done  = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) begin
          if (mmio_if.awlen == '0) w_wnext = W_DATA;
          else                     w_wnext = W_DRAIN;
        end
      end
      W_DATA: begin
        if (w_w_hs) w_wnext = W_LITE;
      end
      W_LITE: begin
        w_aw_done = r_aw_done | w_law_hs;
        w_w_done  = r_w_done | w_lw_hs;
        if (w_aw_done && w_w_done) w_wnext = W_RESP;
      end
      W_RESP: begin
        if (w_lb_hs) w_wnext = W_BOUT;
      end
      W_DRAIN: begin
        if (w_w_hs && mmio_if.wlast) w_wnext = W_BOUT;
      end
      W_BOUT: begin
        if (w_b_hs) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_law_valid <= 1'b0;
      r_lw_valid  <= 1'b0;
      r_lb_ready  <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awid      <= '0;
      r_awaddr    <= '0;
      r_awprot    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bresp     <= '0;
    end else begin
      r_awready   <= (w_wnext == W_IDLE);
      r_wready    <= (w_wnext == W_DATA) ||
                     (w_wnext == W_DRAIN);
      r_law_valid <= (w_wnext == W_LITE) && !w_aw_done;
      r_lw_valid  <= (w_wnext == W_LITE) && !w_w_done;
      r_lb_ready  <= (w_wnext == W_RESP);
      r_bvalid    <= (w_wnext == W_BOUT);
      r_aw_done   <= w_aw_done;
      r_w_done    <= w_w_done;
      if (w_aw_hs) begin
        r_awid   <= mmio_if.awid;
        r_awaddr <= mmio_if.awaddr;
        r_awprot <= mmio_if.awprot;
      end
      if (w_w_hs && r_wstate == W_DATA) begin
        r_wdata <= mmio_if.wdata;
        r_wstrb <= mmio_if.wstrb;
      end
      if (w_lb_hs) begin
        r_bresp <= lite_if.bresp;
      end else if (r_wstate == W_DRAIN && w_w_hs &&
                   mmio_if.wlast) begin
        r_bresp <= SLVERR;
      end
    end
  end

  // Error bursts count down from arlen; 8 bits covers 256 beats.
  always_comb begin
    w_rnext    = r_rstate;
    w_cnt_next = r_cnt;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_cnt_next = mmio_if.arlen;
          if (mmio_if.arlen == '0) w_rnext = R_LITE;
          else                     w_rnext = R_ERR;
        end
      end
      R_LITE: begin
        if (w_lar_hs) w_rnext = R_WAIT;
      end
      R_WAIT: begin
        if (w_lr_hs) w_rnext = R_OUT;
      end
      R_OUT: begin
        if (w_r_hs) w_rnext = R_IDLE;
      end
      R_ERR: begin
        if (w_r_hs) begin
          if (r_cnt == '0) w_rnext = R_IDLE;
          else             w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_lar_valid <= 1'b0;
      r_lr_ready  <= 1'b0;
      r_cnt       <= '0;
      r_arid      <= '0;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_rdata     <= '0;
      r_rresp     <= '0;
    end else begin
      r_arready   <= (w_rnext == R_IDLE);
      r_lar_valid <= (w_rnext == R_LITE);
      r_lr_ready  <= (w_rnext == R_WAIT);
      r_rvalid    <= (w_rnext == R_OUT) ||
                     (w_rnext == R_ERR);
      r_rlast     <= (w_rnext == R_OUT) ||
                     (w_rnext == R_ERR && w_cnt_next == '0);
      r_cnt       <= w_cnt_next;
      if (w_ar_hs) begin
        r_arid   <= mmio_if.arid;
        r_araddr <= mmio_if.araddr;
        r_arprot <= mmio_if.arprot;
        r_rdata  <= '0;
        r_rresp  <= SLVERR;
      end
      if (w_lr_hs) begin
        r_rdata <= lite_if.rdata;
        r_rresp <= lite_if.rresp;
      end
    end
  end

  assign mmio_if.awready = r_awready;
  assign mmio_if.wready  = r_wready;
  assign mmio_if.bvalid  = r_bvalid;
  assign mmio_if.bid     = r_awid;
  assign mmio_if.bresp   = r_bresp;
  assign mmio_if.arready = r_arready;
  assign mmio_if.rvalid  = r_rvalid;
  assign mmio_if.rid     = r_arid;
  assign mmio_if.rdata   = r_rdata;
  assign mmio_if.rresp   = r_rresp;
  assign mmio_if.rlast   = r_rlast;

  assign lite_if.awvalid = r_law_valid;
  assign lite_if.awaddr  = r_awaddr;
  assign lite_if.awprot  = r_awprot;
  assign lite_if.wvalid  = r_lw_valid;
  assign lite_if.wdata   = r_wdata;
  assign lite_if.wstrb   = r_wstrb;
  assign lite_if.bready  = r_lb_ready;
  assign lite_if.arvalid = r_lar_valid;
  assign lite_if.araddr  = r_araddr;
  assign lite_if.arprot  = r_arprot;
  assign lite_if.rready  = r_lr_ready;

endmodule
